cell_sweeper: RTL and testbench

CELL_SWEEPER -- requirements
Module: cell_sweeper

---
 rtl/cell_sweeper_pkg.sv | 21 ++
 rtl/cell_sweeper_misr.sv | 28 ++
 rtl/cell_sweeper.sv | 125 ++++++++++++
 tb/tb_cell_sweeper.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_sweeper_pkg.sv
// Shared types and constants for the cell sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cell_sweeper_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] MISR_POLY   = 8'h1D;
    localparam logic [7:0] MISR_SEED   = 8'h00;
    localparam int         NUM_VECTORS = 8;

    // One MISR compression step: shift left, fold the feedback polynomial
    // back in when the MSB falls off, then mix in the sampled response.
    function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [7:0] din);
        return {m[6:0], 1'b0} ^ (m[7] ? MISR_POLY : 8'h00) ^ din;
    endfunction

endpackage

// File: rtl/cell_sweeper_misr.sv
// 8-bit MISR compacting cell responses; seed has priority over enable.
// Latency: q reflects a seed/step one clock after it is requested.
// Backpressure: none; en is a qualified sample strobe.
//
// Ports: clk, rst_n (sync, active-low), seed (load MISR_SEED),
//        en (compress din into q), din[7:0] response, q[7:0] MISR state.
module cell_sweeper_misr
    import cell_sweeper_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seed,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 8'h00;
        end else if (seed) begin
            q <= MISR_SEED;
        end else if (en) begin
            q <= misr_step(q, din);
        end
    end

endmodule

// File: rtl/cell_sweeper.sv
// Sweeps a 3-bit stimulus vector through a cell wrapper and compacts its response.
// Latency: busy rises 3 clocks after trigger is sampled high; a sweep is 8*2^div clocks.
// Backpressure: none; trigger edges while running are dropped, not queued.
//
// Ports: clk, rst_n (sync, active-low), mode (0 single / 1 continuous),
//        trigger (async switch), div[2:0] dwell exponent, response[7:0] from DUT;
//        source[2:0] stimulus, signature[7:0] last sweep MISR, busy, done pulse.
module cell_sweeper
    import cell_sweeper_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic       trigger,
    input  logic [2:0] div,
    input  logic [7:0] response,
    output logic [2:0] source,
    output logic [7:0] signature,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_VEC = 3'(NUM_VECTORS - 1);

    state_t      state_q, state_d;
    logic        sync1, sync2, sync2_d, edge_r;
    logic [1:0]  warm;
    logic [2:0]  dwell_exp;
    logic [6:0]  presc;
    logic        tick, sweep_end, start, seed;
    logic [7:0]  misr_q;

    // Synchroniser plus registered edge detector. The detector is held off
    // until the pipeline holds three genuine post-reset samples, so a switch
    // already high when reset lifts is not mistaken for a fresh press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            edge_r  <= 1'b0;
            warm    <= 2'd0;
        end else begin
            sync1   <= trigger;
            sync2   <= sync1;
            sync2_d <= sync2;
            edge_r  <= (warm == 2'd3) && sync2 && !sync2_d;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign tick      = (state_q == ST_RUN) &&
                       (presc == 7'((8'd1 << dwell_exp) - 8'd1));
    assign sweep_end = tick && (source == LAST_VEC);
    // A continuous-mode sweep end re-arms exactly like a fresh start.
    assign seed      = start || (sweep_end && mode);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (edge_r) begin
                    state_d = ST_RUN;
                    start   = 1'b1;
                end
            end
            ST_RUN: begin
                if (sweep_end && !mode) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Prescaler, vector counter and result registers. source wraps 7->0 on
    // the final tick, which is also where it must sit after a single sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_exp <= 3'd0;
            presc     <= 7'd0;
            source    <= 3'd0;
            signature <= 8'h00;
            done      <= 1'b0;
        end else begin
            done <= sweep_end;
            if (seed) begin
                dwell_exp <= div;
                presc     <= 7'd0;
                source    <= 3'd0;
            end else if (tick) begin
                presc  <= 7'd0;
                source <= source + 3'd1;
            end else if (state_q == ST_RUN) begin
                presc <= presc + 7'd1;
            end
            if (sweep_end) begin
                signature <= misr_step(misr_q, response);
            end
        end
    end

    assign busy = (state_q == ST_RUN);

    cell_sweeper_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (seed),
        .en    (tick),
        .din   (response),
        .q     (misr_q)
    );

endmodule

// File: tb/tb_cell_sweeper.sv
// Scoreboard bench for cell_sweeper: stimulus pushes expected sweeps, a
// negedge monitor checks source sequencing, sweep length and signature.
// The cell wrapper is modelled as a lookup table indexed by source.
module tb_cell_sweeper;

    logic       clk = 1'b0;
    logic       rst_n, mode, trigger;
    logic [2:0] div;
    logic [7:0] response;
    logic [2:0] source;
    logic [7:0] signature;
    logic       busy, done;

    always #5 clk = ~clk;

    logic [7:0] lut [8];
    assign response = lut[source];

    cell_sweeper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .trigger   (trigger),
        .div       (div),
        .response  (response),
        .source    (source),
        .signature (signature),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [7:0] sig;
        int         dv;
        bit         last;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    int         cnt = 0;
    bit         mon_en = 0;
    logic [7:0] prev_sig = 8'h00;
    logic       rst_at_edge = 1'b0;

    always @(posedge clk) rst_at_edge <= rst_n;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: compress the eight table entries in vector order from seed 0.
    function automatic logic [7:0] ref_sig();
        int m = 0;
        for (int v = 0; v < 8; v++) begin
            m = ((m * 2) % 256) ^ ((m >= 128) ? 'h1D : 0) ^ int'(lut[v]);
        end
        return 8'(m);
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_at_edge) begin
                cnt = 0;
                sb.delete();
                prev_sig = signature;
            end else begin
                if (done) begin
                    exp_t e;
                    done_cnt++;
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("signature", signature, e.sig);
                        check("sweep_len", cnt, 8 << e.dv);
                        check("busy_after_done", busy, e.last ? 0 : 1);
                        if (e.last) check("source_after_done", source, 0);
                    end
                    cnt = 0;
                end else begin
                    check("signature_hold", signature, prev_sig);
                end
                prev_sig = signature;
                if (busy) begin
                    if (sb.size() == 0) begin
                        if (cnt == 0) check("busy_without_request", 1, 0);
                    end else begin
                        check("source_seq", source, (cnt >> sb[0].dv) % 8);
                    end
                    cnt++;
                end
            end
        end
    end

    // Pulses trigger and checks the 3-clock start latency.
    task automatic start_sweep(input bit md, input logic [2:0] dv);
        @(posedge clk); #1;
        mode = md; div = dv; trigger = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy_early", busy, 0);
        @(posedge clk);
        @(negedge clk);
        check("busy_latency", busy, 1);
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_count", done_cnt, target);
    endtask

    task automatic idle_check(input string name, input int cycles);
        int hits = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (busy) hits++;
        end
        check(name, hits, 0);
    endtask

    task automatic single(input logic [2:0] dv, input logic [7:0] sig);
        exp_t e;
        e.sig = sig; e.dv = dv; e.last = 1'b1;
        sb.push_back(e);
        start_sweep(1'b0, dv);
        wait_done(done_cnt + 1, (8 << dv) + 20);
        idle_check("idle_after_single", 4);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   base;
        rst_n = 1'b0; mode = 1'b0; trigger = 1'b0; div = 3'd0;
        for (int i = 0; i < 8; i++) lut[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_source", source, 0);
        check("rst_signature", signature, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        prev_sig = signature;
        mon_en = 1;
        repeat (4) @(posedge clk);

        // All-zero response: signature stays 0.
        single(3'd0, 8'h00);
        // Constant 1 response: 01,03,07,...,FF.
        for (int i = 0; i < 8; i++) lut[i] = 8'h01;
        single(3'd0, 8'hFF);
        // Dwell of 4 clocks per vector.
        for (int i = 0; i < 8; i++) lut[i] = 8'($urandom);
        single(3'd2, ref_sig());

        // Continuous mode, dropped during the second sweep.
        for (int i = 0; i < 8; i++) lut[i] = 8'($urandom);
        base = done_cnt;
        e.sig = ref_sig(); e.dv = 0; e.last = 1'b0; sb.push_back(e);
        e.last = 1'b1; sb.push_back(e);
        start_sweep(1'b1, 3'd0);
        wait_done(base + 1, 30);
        @(posedge clk); #1;
        mode = 1'b0;
        wait_done(base + 2, 30);
        idle_check("idle_after_continuous", 6);

        // Retrigger and div change mid-sweep are ignored.
        for (int i = 0; i < 8; i++) lut[i] = 8'($urandom);
        e.sig = ref_sig(); e.dv = 1; e.last = 1'b1; sb.push_back(e);
        start_sweep(1'b0, 3'd1);
        repeat (2) @(posedge clk);
        #1; trigger = 1'b1; div = 3'd3;
        repeat (3) @(posedge clk);
        #1; trigger = 1'b0;
        wait_done(done_cnt + 1, 40);
        idle_check("no_queued_restart", 20);

        // Randomized single sweeps.
        for (int k = 0; k < 6; k++) begin
            logic [2:0] dv;
            dv = 3'($urandom_range(0, 3));
            for (int i = 0; i < 8; i++) lut[i] = 8'($urandom);
            single(dv, ref_sig());
        end

        // Reset at source=5 aborts the sweep.
        for (int i = 0; i < 8; i++) lut[i] = 8'($urandom);
        e.sig = ref_sig(); e.dv = 0; e.last = 1'b1; sb.push_back(e);
        base = done_cnt;
        start_sweep(1'b0, 3'd0);
        n = 0;
        while (source != 3'd5 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("reach_source5", source, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_source", source, 0);
        check("abort_busy", busy, 0);
        check("abort_signature", signature, 0);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_check("idle_after_abort", 10);
        check("abort_no_done", done_cnt, base);

        // Trigger held high through reset release is not an edge.
        @(posedge clk); #1;
        rst_n = 1'b0; trigger = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        idle_check("held_trigger_ignored", 20);
        @(posedge clk); #1;
        trigger = 1'b0;
        repeat (5) @(posedge clk);

        // Still operational afterwards.
        for (int i = 0; i < 8; i++) lut[i] = 8'($urandom);
        single(3'd1, ref_sig());

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
